// File: rtl/xpe_dot_seq.sv
// Binary XNOR-popcount dot-product sequencer.
// Accepts a job length, then streams weight/activation words through a
// single xpe_core and accumulates the masked popcount into a bipolar result.

// XNOR match count of one word, optionally masked and optionally registered.
module xpe_core #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned HAS_MASK  = 1,
  parameter int unsigned PIPELINE  = 1,
  localparam int unsigned PW       = $clog2(WORD_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [WORD_SIZE-1:0] weight,
  input  logic [WORD_SIZE-1:0] act,
  input  logic [WORD_SIZE-1:0] mask,
  output logic [PW-1:0]        popcount_out
);

  logic [WORD_SIZE-1:0] match_c;
  logic [PW-1:0]        pop_c;

  assign match_c = ~(weight ^ act) & ((HAS_MASK != 0) ? mask : '1);

  // Count matching bit positions.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(WORD_SIZE); i++) begin
      pop_c = pop_c + PW'(match_c[i]);
    end
  end

  if (PIPELINE != 0) begin : g_pipe
    logic [PW-1:0] pop_q;
    // Optional output register; cleared on reset so no stale count survives.
    always_ff @(posedge clk) begin
      if (!rst_n)  pop_q <= '0;
      else if (ce) pop_q <= pop_c;
    end
    assign popcount_out = pop_q;
  end else begin : g_comb
    assign popcount_out = pop_c;
  end

endmodule

module xpe_dot_seq #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned PIPELINE  = 1,
  parameter int unsigned MAX_BITS  = 4096,
  localparam int unsigned LW       = $clog2(MAX_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LW-1:0]        cfg_len_bits,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_weight,
  input  logic [WORD_SIZE-1:0] in_act,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [LW-1:0]        res_popcount,
  output logic signed [LW:0]   res_dot,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(WORD_SIZE + 1);
  localparam int unsigned RW = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        nwords_q, nwords_d;
  logic [LW-1:0]        wcnt_q, wcnt_d;
  logic [LW-1:0]        acc_q, acc_d;
  logic                 cfg_ready_d, in_ready_d, busy_d, res_valid_d;
  logic [LW-1:0]        res_popcount_d;
  logic signed [LW:0]   res_dot_d;

  logic [LW-1:0]        len_clamp_c;
  logic [LW:0]          len_round_c;
  logic [LW-1:0]        nwords_c;
  logic                 beat_c;
  logic                 last_c;
  logic [RW-1:0]        rem_c;
  logic [WORD_SIZE-1:0] mask_c;
  logic [PW-1:0]        pop_c;
  logic                 tag_c;

  assign len_clamp_c = (cfg_len_bits > LW'(MAX_BITS)) ? LW'(MAX_BITS) : cfg_len_bits;
  assign len_round_c = {1'b0, len_clamp_c} + (LW+1)'(WORD_SIZE - 1);
  assign nwords_c    = LW'(len_round_c / (LW+1)'(WORD_SIZE));

  assign beat_c = in_valid & in_ready;
  assign last_c = (wcnt_q == nwords_q - LW'(1));
  assign rem_c  = RW'(len_q % LW'(WORD_SIZE));
  // Only the tail of the final word is trimmed; an exact multiple keeps all bits.
  assign mask_c = (last_c && (rem_c != '0)) ? ~({WORD_SIZE{1'b1}} << rem_c) : '1;

  xpe_core #(
    .WORD_SIZE (WORD_SIZE),
    .HAS_MASK  (1),
    .PIPELINE  (PIPELINE)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (1'b1),
    .weight       (in_weight),
    .act          (in_act),
    .mask         (mask_c),
    .popcount_out (pop_c)
  );

  if (PIPELINE != 0) begin : g_tag
    logic tag_q;
    // Valid tag follows the beat through the core register.
    always_ff @(posedge clk) begin
      if (!rst_n) tag_q <= 1'b0;
      else        tag_q <= beat_c;
    end
    assign tag_c = tag_q;
  end else begin : g_tag_comb
    assign tag_c = beat_c;
  end

  // Next-state, bookkeeping and next-output decode.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    nwords_d = nwords_q;
    wcnt_d   = wcnt_q;
    acc_d    = acc_q;

    if (tag_c) acc_d = acc_q + LW'(pop_c);

    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          len_d    = len_clamp_c;
          nwords_d = nwords_c;
          wcnt_d   = '0;
          acc_d    = '0;
          state_d  = (len_clamp_c == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (beat_c) begin
          wcnt_d = wcnt_q + LW'(1);
          if (last_c) state_d = (PIPELINE != 0) ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cfg_ready_d    = (state_d == S_IDLE);
    in_ready_d     = (state_d == S_STREAM);
    busy_d         = (state_d != S_IDLE);
    res_valid_d    = (state_d == S_DONE);
    res_popcount_d = acc_d;
    res_dot_d      = (LW+1)'({acc_d, 1'b0}) - (LW+1)'(len_d);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      nwords_q     <= '0;
      wcnt_q       <= '0;
      acc_q        <= '0;
      cfg_ready    <= 1'b1;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_popcount <= '0;
      res_dot      <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      nwords_q     <= nwords_d;
      wcnt_q       <= wcnt_d;
      acc_q        <= acc_d;
      cfg_ready    <= cfg_ready_d;
      in_ready     <= in_ready_d;
      busy         <= busy_d;
      res_valid    <= res_valid_d;
      res_popcount <= res_popcount_d;
      res_dot      <= res_dot_d;
    end
  end

endmodule

// File: tb/tb_xpe_dot_seq.sv
// Directed bench for xpe_dot_seq with default parameters (64-bit words, PIPELINE=1).
module tb_xpe_dot_seq;

  localparam int unsigned WS   = 64;
  localparam int unsigned LW   = 13;
  localparam int          PIPE = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [LW-1:0]        cfg_len_bits;
  logic                 in_valid;
  logic                 in_ready;
  logic [WS-1:0]        in_weight;
  logic [WS-1:0]        in_act;
  logic                 res_valid;
  logic                 res_ready;
  logic [LW-1:0]        res_popcount;
  logic signed [LW:0]   res_dot;
  logic                 busy;

  xpe_dot_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_len_bits (cfg_len_bits),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_weight    (in_weight),
    .in_act       (in_act),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_popcount (res_popcount),
    .res_dot      (res_dot),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          len;
    int          nb;
    logic [WS-1:0] w [3];
    logic [WS-1:0] a [3];
    int          gap;
    int          hold;
    bit          extra;
    bit          poke;
    int          exp_pop;
    int          exp_dot;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for res_valid, bounded; returns cycles waited.
  task automatic wait_result(output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result(input string name);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, "_rv_drop"}, res_valid, 0);
    check({name, "_cfg_rdy_back"}, cfg_ready, 1);
  endtask

  task automatic do_job(input vec_t v, input string name);
    int lat;
    check({name, "_cfg_ready"}, cfg_ready, 1);
    cfg_len_bits = LW'(v.len);
    cfg_valid    = 1'b1;
    @(negedge clk);
    cfg_valid    = 1'b0;
    check({name, "_busy"}, busy, 1);
    for (int b = 0; b < v.nb; b++) begin
      if (b > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          if (v.poke) begin
            cfg_valid    = 1'b1;
            cfg_len_bits = LW'(64);
          end
          @(negedge clk);
          cfg_valid = 1'b0;
        end
      end
      check($sformatf("%s_in_ready_b%0d", name, b), in_ready, 1);
      in_weight = v.w[b];
      in_act    = v.a[b];
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid  = v.extra && (b == v.nb - 1);
    end
    if (v.extra) check({name, "_in_ready_drop"}, in_ready, 0);
    wait_result(lat);
    check({name, "_latency"}, lat, (v.nb == 0) ? 0 : PIPE);
    check({name, "_pop"}, res_popcount, v.exp_pop);
    check({name, "_dot"}, res_dot, v.exp_dot);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d_rv", name, h), res_valid, 1);
      check($sformatf("%s_hold%0d_pop", name, h), res_popcount, v.exp_pop);
      check($sformatf("%s_hold%0d_dot", name, h), res_dot, v.exp_dot);
      check($sformatf("%s_hold%0d_cfg_rdy", name, h), cfg_ready, 0);
    end
    in_valid = 1'b0;
    release_result(name);
  endtask

  initial begin
    int lat;
    vec_t z;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_len_bits = '0; in_valid = 1'b0;
    in_weight = '0; in_act = '0; res_ready = 1'b0;

    // len, nbeats, weights, acts, gap, hold, extra, poke, pop, dot
    vecs[0] = '{128, 2, '{64'h0, 64'h0, 64'h0}, '{64'h0, 64'h0, 64'h0}, 1, 0, 1'b0, 1'b1, 128, 128};
    vecs[1] = '{64, 1, '{'1, 64'h0, 64'h0}, '{64'h0, 64'h0, 64'h0}, 0, 0, 1'b0, 1'b0, 0, -64};
    vecs[2] = '{96, 2, '{64'h0, 64'hFFFFFFFF_00000000, 64'h0}, '{64'h0, 64'h0, 64'h0}, 0, 0, 1'b0, 1'b0, 96, 96};
    vecs[3] = '{5, 1, '{64'h1F, 64'h0, 64'h0}, '{64'h1E, 64'h0, 64'h0}, 0, 0, 1'b0, 1'b0, 4, 3};
    vecs[4] = '{70, 2, '{64'hFFFF, 64'h0, 64'h0}, '{64'h0, 64'h0, 64'h0}, 1, 0, 1'b0, 1'b0, 54, 38};
    vecs[5] = '{192, 3, '{64'hDEADBEEF_CAFEF00D, 64'h01234567_89ABCDEF, 64'hFFFF0000_FFFF0000},
                        '{64'hDEADBEEF_CAFEF00D, 64'h01234567_89ABCDEF, 64'hFFFF0000_FFFF0000},
                2, 3, 1'b1, 1'b0, 192, 192};

    repeat (2) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_pop", res_popcount, 0);
    check("rst_dot", res_dot, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_job(vecs[i], $sformatf("v%0d", i));
    end

    // Zero-length job completes straight away with 0/0.
    z = '{0, 0, '{64'h0, 64'h0, 64'h0}, '{64'h0, 64'h0, 64'h0}, 0, 1, 1'b0, 1'b0, 0, 0};
    do_job(z, "len0");

    // Oversized length clamps to MAX_BITS (64 words).
    cfg_len_bits = '1;
    cfg_valid    = 1'b1;
    @(negedge clk);
    cfg_valid    = 1'b0;
    in_weight    = '0;
    in_act       = '0;
    in_valid     = 1'b1;
    for (int b = 0; b < 64; b++) @(negedge clk);
    in_valid = 1'b0;
    check("clamp_in_ready_drop", in_ready, 0);
    wait_result(lat);
    check("clamp_latency", lat, PIPE);
    check("clamp_pop", res_popcount, 4096);
    check("clamp_dot", res_dot, 4096);
    release_result("clamp");

    // Reset after the first of three beats discards the job.
    cfg_len_bits = LW'(192);
    cfg_valid    = 1'b1;
    @(negedge clk);
    cfg_valid    = 1'b0;
    in_weight    = 64'h5555;
    in_act       = 64'h5555;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid     = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    check("mrst_res_valid", res_valid, 0);
    check("mrst_pop", res_popcount, 0);
    check("mrst_dot", res_dot, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    check("mrst_idle_pop", res_popcount, 0);
    z = '{64, 1, '{64'h0F, 64'h0, 64'h0}, '{64'h0, 64'h0, 64'h0}, 0, 0, 1'b0, 1'b0, 60, 56};
    do_job(z, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xpe_dot_seq.md
XPE_DOT_SEQ -- requirements
Module: xpe_dot_seq

Interface
REQ-001 Parameter WORD_SIZE, default 64: bits per weight/activation word.
REQ-002 Parameter PIPELINE, default 1: latency of the internal xpe_core popcount path, 0 or 1.
REQ-003 Parameter MAX_BITS, default 4096: maximum vector length in bits; LW = $clog2(MAX_BITS+1).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 cfg_valid  in  1  job start request.
REQ-007 cfg_ready  out  1  high only in IDLE.
REQ-008 cfg_len_bits  in  LW  vector length in bits for the job.
REQ-009 in_valid  in  1  word beat valid.
REQ-010 in_ready  out  1  high only in STREAM.
REQ-011 in_weight, in_act  in  WORD_SIZE each  binary weight and activation words, LSB-first within the vector.
REQ-012 res_valid  out  1  result available.
REQ-013 res_ready  in  1  result consumed.
REQ-014 res_popcount  out  LW  total XNOR popcount over the valid bits.
REQ-015 res_dot  out  LW+1 signed  bipolar dot product.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 Block SHALL contain one xpe_core (HAS_MASK=1, PIPELINE as set) with ce tied high; all accumulation bookkeeping is in this block.
REQ-018 FSM states: IDLE, STREAM, DRAIN, DONE.
REQ-019 IDLE, cfg_valid&cfg_ready: latch len = min(cfg_len_bits, MAX_BITS); nwords = ceil(len/WORD_SIZE); clear accumulator; go STREAM; len==0 goes directly to DONE with both results 0.
REQ-020 STREAM: a beat is accepted when in_valid&in_ready; beats with in_valid low are bubbles and SHALL NOT alter the word counter or the accumulator.
REQ-021 Mask: all ones for every non-final beat; on the final beat, the low (len mod WORD_SIZE) bits are set, or all ones when the remainder is 0.
REQ-022 A valid tag SHALL travel alongside the data, delayed PIPELINE cycles; the accumulator adds popcount_out only when the delayed tag is set.
REQ-023 Final beat accepted at edge k: PIPELINE=0 enters DONE at edge k; PIPELINE=1 enters DRAIN at k and DONE at k+1, with the final popcount already added.
REQ-024 DONE: res_valid=1; res_popcount = accumulator; res_dot = 2*res_popcount - len, with signed arithmetic in LW+1 bits.
REQ-025 Outputs SHALL hold stable while res_valid&!res_ready; on res_ready go IDLE, and res_valid drops the next cycle.
REQ-026 cfg_valid outside IDLE SHALL be ignored; no job queuing.
REQ-027 Accumulator SHALL never overflow: sum of popcounts is at most len, which is at most MAX_BITS.
REQ-028 in_ready SHALL drop in the cycle after the final beat is accepted; extra beats are not consumed.

Reset
REQ-029 rst_n low at a clock edge: state IDLE; accumulator, counters, delayed valid tag, len = 0.
REQ-030 After reset: res_valid=0, res_popcount=0, res_dot=0, in_ready=0, busy=0, cfg_ready=1.
REQ-031 Reset mid-job SHALL discard all in-flight beats, including any inside xpe_core; the next job is unaffected.

Verification
REQ-032 len=128, two beats w=0,a=0 -> res_popcount=128, res_dot=+128; res_valid PIPELINE cycles after the last beat.
REQ-033 len=64, one beat w=all ones, a=0 -> res_popcount=0, res_dot=-64.
REQ-034 len=96, beat0 w=a=0; beat1 w=0xFFFFFFFF_00000000, a=0 -> res_popcount=96, res_dot=+96 (upper bits masked).
REQ-035 len=192, three beats w=a with in_valid gaps of 2 cycles, res_ready held low 3 cycles -> res_popcount=192; outputs stable and cfg_ready=0 until handshake.
REQ-036 rst_n pulsed after 1 of 3 beats of a len=192 job, then new job len=64, w=0x0F, a=0 -> post-reset outputs 0; result res_popcount=60, res_dot=+56.
REQ-037 cfg_len_bits=0 -> DONE next cycle with 0/0; cfg_valid asserted during STREAM -> ignored, job result unchanged.
